// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC oscillator family: fixed-point word
// format constants and the tuning sweep controller state encoding.
package cordic_pkg;

    localparam int SFIXED_WIDTH = 32;
    localparam logic signed [SFIXED_WIDTH-1:0] SFIXED_TWO_PI = 32'sh6487ED51;
    localparam logic signed [SFIXED_WIDTH-1:0] SFIXED_ZERO   = 32'sh0000_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/sweep_dwell_counter.sv
// Dwell counter: counts sample strobes and raises expire on the strobe that
// completes limit+1 strobes. expire is combinational so the owner can act on
// the same clock edge that wraps the count.
module sweep_dwell_counter #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ce,
    input  logic                   clear,
    input  logic [DWELL_WIDTH-1:0] limit,
    output logic                   expire
);

    localparam logic [DWELL_WIDTH-1:0] COUNT_ZERO = {DWELL_WIDTH{1'b0}};
    localparam logic [DWELL_WIDTH-1:0] COUNT_ONE  = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

    logic [DWELL_WIDTH-1:0] count_r;

    assign expire = ce && !clear && (count_r == limit);

    // Strobe counter: synchronous clear wins, otherwise advance/wrap on ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= COUNT_ZERO;
        end else if (clear) begin
            count_r <= COUNT_ZERO;
        end else if (ce) begin
            if (count_r == limit) begin
                count_r <= COUNT_ZERO;
            end else begin
                count_r <= count_r + COUNT_ONE;
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/tuning_sweep_ctrl.sv
// Tuning sweep controller: drives a stepped chirp onto the oscillator tuning
// word, either a single up-ramp or a continuous triangle, stepping only on
// sample strobes so each word lasts an exact number of samples.
module tuning_sweep_ctrl #(
    parameter int                              SFIXED_WIDTH  = 32,
    parameter logic signed [SFIXED_WIDTH-1:0]  SFIXED_TWO_PI = 32'sh6487ED51,
    parameter int                              DWELL_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ce,
    input  logic                           start,
    input  logic                           abort,
    input  logic signed [SFIXED_WIDTH-1:0] cfg_start_word,
    input  logic signed [SFIXED_WIDTH-1:0] cfg_stop_word,
    input  logic signed [SFIXED_WIDTH-1:0] cfg_step,
    input  logic        [DWELL_WIDTH-1:0]  cfg_dwell,
    input  logic                           cfg_mode,
    output logic signed [SFIXED_WIDTH-1:0] tuning_word,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err
);

    import cordic_pkg::*;

    localparam logic signed [SFIXED_WIDTH-1:0] WORD_ZERO  = {SFIXED_WIDTH{1'b0}};
    localparam logic        [DWELL_WIDTH-1:0]  DWELL_ZERO = {DWELL_WIDTH{1'b0}};

    sweep_state_e state_r, state_next_s;

    // Shadow copy of the configuration taken at start.
    logic signed [SFIXED_WIDTH-1:0] start_word_r, stop_word_r, step_r;
    logic        [DWELL_WIDTH-1:0]  dwell_r;
    logic                           mode_r;

    logic signed [SFIXED_WIDTH-1:0] tuning_word_r, word_next_s;
    logic                           busy_r, done_r, cfg_err_r;
    logic                           done_next_s, cfg_err_next_s, latch_s;
    logic                           cfg_legal_s, expire_s, dwell_clear_s;

    // One extra bit keeps the step sum/difference from wrapping before clamp.
    logic signed [SFIXED_WIDTH:0]   up_sum_s, down_diff_s, start_ext_s, stop_ext_s;
    logic signed [SFIXED_WIDTH-1:0] up_word_s, down_word_s;

    assign cfg_legal_s = (cfg_start_word >= WORD_ZERO) &&
                         (cfg_start_word <  cfg_stop_word) &&
                         (cfg_stop_word  <= SFIXED_TWO_PI) &&
                         (cfg_step       >  WORD_ZERO);

    assign start_ext_s = $signed({start_word_r[SFIXED_WIDTH-1], start_word_r});
    assign stop_ext_s  = $signed({stop_word_r[SFIXED_WIDTH-1], stop_word_r});
    assign up_sum_s    = $signed({tuning_word_r[SFIXED_WIDTH-1], tuning_word_r})
                       + $signed({step_r[SFIXED_WIDTH-1], step_r});
    assign down_diff_s = $signed({tuning_word_r[SFIXED_WIDTH-1], tuning_word_r})
                       - $signed({step_r[SFIXED_WIDTH-1], step_r});
    assign up_word_s   = (up_sum_s >= stop_ext_s)    ? stop_word_r  : up_sum_s[SFIXED_WIDTH-1:0];
    assign down_word_s = (down_diff_s <= start_ext_s) ? start_word_r : down_diff_s[SFIXED_WIDTH-1:0];

    // The counter restarts from zero whenever no sweep is running, so the
    // first word after start gets its full dwell.
    assign dwell_clear_s = (state_r == IDLE);

    sweep_dwell_counter #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .clear  (dwell_clear_s),
        .limit  (dwell_r),
        .expire (expire_s)
    );

    // Next-state and next-output decode; abort overrides every other event.
    always_comb begin
        state_next_s   = state_r;
        word_next_s    = tuning_word_r;
        done_next_s    = 1'b0;
        cfg_err_next_s = 1'b0;
        latch_s        = 1'b0;
        if (abort) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (cfg_legal_s) begin
                            latch_s      = 1'b1;
                            word_next_s  = cfg_start_word;
                            state_next_s = RUN_UP;
                        end else begin
                            cfg_err_next_s = 1'b1;
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                RUN_UP: begin
                    if (expire_s) begin
                        if (tuning_word_r == stop_word_r) begin
                            if (mode_r) begin
                                word_next_s  = down_word_s;
                                state_next_s = RUN_DOWN;
                            end else begin
                                done_next_s  = 1'b1;
                                state_next_s = IDLE;
                            end
                        end else begin
                            word_next_s = up_word_s;
                        end
                    end else begin
                        state_next_s = RUN_UP;
                    end
                end
                RUN_DOWN: begin
                    if (expire_s) begin
                        if (tuning_word_r == start_word_r) begin
                            word_next_s  = up_word_s;
                            state_next_s = RUN_UP;
                        end else begin
                            word_next_s = down_word_s;
                        end
                    end else begin
                        state_next_s = RUN_DOWN;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shadow configuration, captured only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_word_r <= WORD_ZERO;
            stop_word_r  <= WORD_ZERO;
            step_r       <= WORD_ZERO;
            dwell_r      <= DWELL_ZERO;
            mode_r       <= 1'b0;
        end else if (latch_s) begin
            start_word_r <= cfg_start_word;
            stop_word_r  <= cfg_stop_word;
            step_r       <= cfg_step;
            dwell_r      <= cfg_dwell;
            mode_r       <= cfg_mode;
        end else begin
            start_word_r <= start_word_r;
            stop_word_r  <= stop_word_r;
            step_r       <= step_r;
            dwell_r      <= dwell_r;
            mode_r       <= mode_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tuning_word_r <= WORD_ZERO;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            cfg_err_r     <= 1'b0;
        end else begin
            tuning_word_r <= word_next_s;
            busy_r        <= (state_next_s != IDLE);
            done_r        <= done_next_s;
            cfg_err_r     <= cfg_err_next_s;
        end
    end

    assign tuning_word = tuning_word_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_tuning_sweep_ctrl.sv
// Self-checking bench for tuning_sweep_ctrl: directed scenarios plus random
// traffic, compared against a sweep model that indexes the word sequence
// arithmetically rather than stepping a word register.
module tb_tuning_sweep_ctrl;

    localparam longint TWO_PI = 64'sh6487ED51;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0, start = 1'b0, abort = 1'b0, cfg_mode = 1'b0;
    logic [31:0] cfg_start_word = 32'h0, cfg_stop_word = 32'h0, cfg_step = 32'h0;
    logic [15:0] cfg_dwell = 16'h0;
    logic [31:0] tuning_word;
    logic        busy, done, cfg_err;

    int n_checks = 0;
    int n_pass   = 0;

    tuning_sweep_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ce             (ce),
        .start          (start),
        .abort          (abort),
        .cfg_start_word (cfg_start_word),
        .cfg_stop_word  (cfg_stop_word),
        .cfg_step       (cfg_step),
        .cfg_dwell      (cfg_dwell),
        .cfg_mode       (cfg_mode),
        .tuning_word    (tuning_word),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    // Run-time guard.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // ---------------- reference model ----------------
    bit          m_active, m_done, m_err, m_mode;
    longint      m_s, m_e, m_step, m_idx, m_nup;
    int          m_cnt, m_dwell;
    logic [31:0] m_word;

    function automatic bit legal(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st);
        longint ls, le, lst;
        ls  = longint'($signed(s));
        le  = longint'($signed(e));
        lst = longint'($signed(st));
        return (ls >= 0) && (ls < le) && (le <= TWO_PI) && (lst > 0);
    endfunction

    // Word at position i of the sweep: start, then the up ramp to stop, then
    // the down ramp back to start, with the up+down ramps repeating.
    function automatic logic [31:0] word_at(input longint i);
        longint k, v;
        if (i == 0) return m_s[31:0];
        k = (i - 1) % (2 * m_nup);
        if (k < m_nup) begin
            v = m_s + (k + 1) * m_step;
            if (v > m_e) v = m_e;
        end else begin
            v = m_e - (k - m_nup + 1) * m_step;
            if (v < m_s) v = m_s;
        end
        return v[31:0];
    endfunction

    task automatic model_reset();
        m_active = 0; m_done = 0; m_err = 0; m_word = 32'h0;
    endtask

    task automatic model_edge();
        m_done = 0;
        m_err  = 0;
        if (abort) begin
            m_active = 0;
        end else if (!m_active) begin
            if (start) begin
                if (legal(cfg_start_word, cfg_stop_word, cfg_step)) begin
                    m_s      = longint'($signed(cfg_start_word));
                    m_e      = longint'($signed(cfg_stop_word));
                    m_step   = longint'($signed(cfg_step));
                    m_dwell  = int'(cfg_dwell);
                    m_mode   = cfg_mode;
                    m_nup    = (m_e - m_s + m_step - 1) / m_step;
                    m_active = 1; m_idx = 0; m_cnt = 0;
                    m_word   = word_at(0);
                end else begin
                    m_err = 1;
                end
            end
        end else if (ce) begin
            m_cnt++;
            if (m_cnt > m_dwell) begin
                m_cnt = 0;
                if (!m_mode && m_idx == m_nup) begin
                    m_active = 0;
                    m_done   = 1;
                end else begin
                    m_idx++;
                    m_word = word_at(m_idx);
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("word", tuning_word, m_word);
        check_eq("busy", {31'h0, busy},    {31'h0, m_active});
        check_eq("done", {31'h0, done},    {31'h0, m_done});
        check_eq("cfg_err", {31'h0, cfg_err}, {31'h0, m_err});
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [15:0] dw, input logic md);
        cfg_start_word = s; cfg_stop_word = e; cfg_step = st; cfg_dwell = dw; cfg_mode = md;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic run_until_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && m_active; i++) cyc();
        check_eq("idle_reached", {31'h0, busy}, 32'h0);
    endtask

    task automatic gen_cfg();
        logic [31:0] s, e, st;
        int sel, k;
        sel = $urandom_range(0, 11);
        st  = $urandom_range(1, 32'h100);
        s   = $urandom_range(0, 32'h10000);
        k   = $urandom_range(1, 6);
        e   = s + st * (k - 1) + $urandom_range(1, st);
        case (sel)
            0: st = 32'h0;
            1: e = s;
            2: begin s = 32'h6487ED51 - $urandom_range(1, 32'h400); e = 32'h6487ED51;
                     st = $urandom_range(32'h80, 32'h200); end
            3: begin s = 32'h6487ED00; e = 32'h6487ED52; end
            4: s = 32'h8000_0000 | s;
            5: e = s - 32'h1;
            default: ;
        endcase
        set_cfg(s, e, st, 16'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        model_reset();
        #3;
        check_eq("reset_word", tuning_word, 32'h0);
        check_eq("reset_busy", {31'h0, busy}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        ce = 1'b1;

        // Single-shot basic, start in cycle 0
        set_cfg(32'h100, 32'h400, 32'h100, 16'd2, 1'b0);
        pulse_start();                                   // now in cycle 1
        check_eq("basic_c1", tuning_word, 32'h100);
        cyc(); cyc();                                    // cycle 3
        check_eq("basic_c3", tuning_word, 32'h100);
        cyc();                                           // cycle 4
        check_eq("basic_c4", tuning_word, 32'h200);
        for (int i = 0; i < 8; i++) cyc();               // cycle 12
        check_eq("basic_c12", tuning_word, 32'h400);
        cyc();                                           // cycle 13
        check_eq("basic_done", {31'h0, done}, 32'h1);
        check_eq("basic_busy", {31'h0, busy}, 32'h0);
        cyc();
        check_eq("basic_hold", tuning_word, 32'h400);

        // Clamp at a stop that is not a multiple of the step
        set_cfg(32'h100, 32'h350, 32'h100, 16'd0, 1'b0);
        pulse_start(); cyc(); cyc(); cyc();
        check_eq("clamp_last", tuning_word, 32'h350);
        run_until_idle(20);

        // Triangle, one word per cycle
        set_cfg(32'h100, 32'h300, 32'h100, 16'd0, 1'b1);
        pulse_start(); cyc(); cyc(); cyc();
        check_eq("tri_turn", tuning_word, 32'h200);
        for (int i = 0; i < 20; i++) cyc();
        check_eq("tri_busy", {31'h0, busy}, 32'h1);
        // start while busy is ignored
        set_cfg(32'h0, 32'h10, 32'h1, 16'd0, 1'b0);
        pulse_start();
        abort = 1'b1; cyc(); abort = 1'b0;
        cyc();

        // ce every 4th clock
        set_cfg(32'h100, 32'h400, 32'h100, 16'd2, 1'b0);
        ce = 1'b0;
        pulse_start();
        for (int i = 0; i < 60 && m_active; i++) begin
            ce = (i % 4 == 3); cyc();
        end
        ce = 1'b1;
        run_until_idle(10);

        // Illegal configurations
        set_cfg(32'h100, 32'h100, 32'h10, 16'd0, 1'b0);        pulse_start();
        check_eq("err_eq", {31'h0, cfg_err}, 32'h1);
        set_cfg(32'h100, 32'h400, 32'h0, 16'd0, 1'b0);         pulse_start();
        check_eq("err_step0", {31'h0, cfg_err}, 32'h1);
        set_cfg(32'h100, 32'h6487ED52, 32'h10, 16'd0, 1'b0);   pulse_start();
        check_eq("err_2pi", {31'h0, cfg_err}, 32'h1);
        // start + abort together
        set_cfg(32'h100, 32'h400, 32'h100, 16'd0, 1'b0);
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        check_eq("startabort_busy", {31'h0, busy}, 32'h0);

        // Abort at word 0x200
        set_cfg(32'h100, 32'h400, 32'h100, 16'd1, 1'b0);
        pulse_start(); cyc(); cyc();
        abort = 1'b1; cyc(); abort = 1'b0;
        check_eq("abort_word", tuning_word, 32'h200);
        check_eq("abort_done", {31'h0, done}, 32'h0);
        cyc();

        // Async reset mid-sweep
        pulse_start(); cyc(); cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_word", tuning_word, 32'h0);
        check_eq("arst_busy", {31'h0, busy}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Random traffic, configuration churning underneath running sweeps
        for (int i = 0; i < 4000; i++) begin
            gen_cfg();
            ce    = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 149) == 0);
            cyc();
        end
        start = 1'b0; abort = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
